klein_80_dec: RTL

Iterative KLEIN-80 decryption core, the inverse of the team's KLEIN-80 encryption core (`klein_80`). It takes a 64-bit ciphertext and the 80-bit cipher key and runs an optional 16-cycle forward key expansion to reach the final round key. It then runs 16 inverse rounds, one per cycle, while unrolling the key schedule backwards. It sits beside the encryptor in the DPA evaluation datapath and shares its bit ordering (bit 0 = MSB).

---
 rtl/klein_pkg.sv | 61 ++++++
 rtl/sbox.sv | 31 +++
 rtl/klein_80_dec.sv | 125 ++++++++++++
 3 files changed

// File: rtl/klein_pkg.sv
// Shared constants, FSM encoding and key-schedule helpers for the KLEIN-80 cores.
// KLEIN bit 0 (the MSB) maps to the top index of each descending vector here.
// So KLEIN bits [0:63] of an 80-bit key are [79:16].
package klein_pkg;

  localparam int unsigned KLEIN_ROUNDS = 16;
  localparam int unsigned KLEIN_KEY_W  = 80;
  localparam int unsigned KLEIN_BLK_W  = 64;

  typedef enum logic [1:0] {StIdle, StKexp, StDec, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (up to 0x0f) in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Inverse MixColumns on one 32-bit half; byte 0 is the most significant byte.
  function automatic logic [31:0] inv_mix_half(input logic [31:0] h);
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int j = 0; j < 4; j++) a[j] = h[31-8*j -: 8];
    for (int j = 0; j < 4; j++) begin
      r[31-8*j -: 8] = gf_mul(a[j], 4'he) ^ gf_mul(a[(j+1)%4], 4'hb) ^
                       gf_mul(a[(j+2)%4], 4'hd) ^ gf_mul(a[(j+3)%4], 4'h9);
    end
    return r;
  endfunction

  // Forward key step up to (not including) the S-boxes on KLEIN bits [48:63].
  function automatic logic [79:0] fwd_key_pre(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] krot;
    logic [79:0] kfei;
    krot = {k[71:40], k[79:72], k[31:0], k[39:32]};
    kfei = {krot[39:0], krot[79:40] ^ krot[39:0]};
    kfei[63:56] = kfei[63:56] ^ {3'b000, c};
    return kfei;
  endfunction

  // Inverse key step; f already has the S-boxes on KLEIN bits [48:63] undone.
  function automatic logic [79:0] inv_key_post(input logic [79:0] f, input logic [4:0] c);
    logic [79:0] g;
    logic [79:0] krot;
    g = f;
    g[63:56] = g[63:56] ^ {3'b000, c};
    krot = {g[39:0] ^ g[79:40], g[79:40]};
    return {krot[47:40], krot[79:48], krot[7:0], krot[39:8]};
  endfunction

endpackage

// File: rtl/sbox.sv
// KLEIN 4-bit S-box. The table is an involution, so it also serves as its own inverse.
module sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Table lookup
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'h7;
      4'h1: dout = 4'h4;
      4'h2: dout = 4'ha;
      4'h3: dout = 4'h9;
      4'h4: dout = 4'h1;
      4'h5: dout = 4'hf;
      4'h6: dout = 4'hb;
      4'h7: dout = 4'h0;
      4'h8: dout = 4'hc;
      4'h9: dout = 4'h3;
      4'ha: dout = 4'h2;
      4'hb: dout = 4'h6;
      4'hc: dout = 4'h8;
      4'hd: dout = 4'he;
      4'he: dout = 4'hd;
      4'hf: dout = 4'h5;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/klein_80_dec.sv
// Iterative KLEIN-80 decryption core: one inverse round per cycle, key schedule unrolled backwards.
// KLEIN80_DEC_KEYEXP_EN: when defined, `key` is the cipher key and a 16-cycle forward expansion
// runs first. Otherwise `key` must be the final round key k16.
module klein_80_dec
  import klein_pkg::*;
(
  input  logic                   ck,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KLEIN_BLK_W-1:0] inp,
  input  logic [KLEIN_KEY_W-1:0] key,
  output logic                   busy,
  output logic                   ready,
  output logic [KLEIN_BLK_W-1:0] out
);

  localparam logic [3:0] LastCnt = 4'(KLEIN_ROUNDS - 1);

  state_e      fsm;
  logic [3:0]  cnt;
  logic [63:0] state;
  logic [79:0] kstate;

  // Round constant: the forward step into k_{cnt+1} and the inverse step out of it both use it.
  logic [4:0] rc;
  assign rc = {1'b0, cnt} + 5'd1;

  // Inverse key step k_{r+1} -> k_r
  logic [15:0] kinv_sb;
  logic [79:0] k_r;
  for (genvar i = 0; i < 4; i++) begin : g_kinv_sbox
    sbox u_sbox (
      .din  (kstate[16+4*i +: 4]),
      .dout (kinv_sb[4*i +: 4])
    );
  end
  assign k_r = inv_key_post({kstate[79:32], kinv_sb, kstate[15:0]}, rc);

  // Inverse round datapath: InvMix, rotate right 16, InvS, add k_r
  logic [63:0] mixed;
  logic [63:0] rotated;
  logic [63:0] subbed;
  logic [63:0] round_out;
  assign mixed   = {inv_mix_half(state[63:32]), inv_mix_half(state[31:0])};
  assign rotated = {mixed[15:0], mixed[63:16]};
  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    sbox u_sbox (
      .din  (rotated[4*i +: 4]),
      .dout (subbed[4*i +: 4])
    );
  end
  assign round_out = subbed ^ k_r[79:16];

`ifdef KLEIN80_DEC_KEYEXP_EN
  // Forward key step k_cnt -> k_{cnt+1}, identical to the encryptor's schedule
  logic [79:0] kfwd_pre;
  logic [15:0] kfwd_sb;
  logic [79:0] kfwd;
  assign kfwd_pre = fwd_key_pre(kstate, rc);
  for (genvar i = 0; i < 4; i++) begin : g_kfwd_sbox
    sbox u_sbox (
      .din  (kfwd_pre[16+4*i +: 4]),
      .dout (kfwd_sb[4*i +: 4])
    );
  end
  assign kfwd = {kfwd_pre[79:32], kfwd_sb, kfwd_pre[15:0]};
`endif

  // Control FSM with registered state, key, counter and outputs
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= StIdle;
      cnt    <= 4'd0;
      state  <= 64'd0;
      kstate <= 80'd0;
      out    <= 64'd0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else if (start) begin
      // A new block always wins; any run in flight is dropped
      kstate <= key;
      ready  <= 1'b0;
      busy   <= 1'b1;
`ifdef KLEIN80_DEC_KEYEXP_EN
      cnt    <= 4'd0;
      state  <= inp;
      fsm    <= StKexp;
`else
      cnt    <= LastCnt;
      state  <= inp ^ key[79:16];
      fsm    <= StDec;
`endif
    end else begin
      case (fsm)
`ifdef KLEIN80_DEC_KEYEXP_EN
        StKexp: begin
          kstate <= kfwd;
          if (cnt == LastCnt) begin
            // Whitening uses k16 straight from the combinational step
            state <= state ^ kfwd[79:16];
            fsm   <= StDec;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`endif
        StDec: begin
          state  <= round_out;
          kstate <= k_r;
          if (cnt == 4'd0) begin
            out   <= round_out;
            fsm   <= StDone;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StIdle, StDone: ;
        default: fsm <= StIdle;
      endcase
    end
  end

endmodule
